clint_timer: RTL and testbench

- Core-local interruptor: machine timer (mtime/mtimecmp) and machine software interrupt (msip) registers, memory-mapped on the data bus.
- Sits directly upstream of the M-mode CSR file and drives its timer_int_in and software_int_in inputs.
- Exports mtime for counter/time reads.
- Single hart, single clock domain.

---
 rtl/clint_timer_if.sv | 26 ++
 rtl/clint_timer.sv | 130 +++++++++++++
 tb/tb_clint_timer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/clint_timer_if.sv
// Bus interface between the data-bus master and the CLINT register block.
// One request channel (valid/ready, write enable, byte address, write data,
// byte strobes) and one response channel (valid pulse, read data, error).
//   master : drives the request fields, receives ready and the response
//   slave  : receives the request fields, drives ready and the response
interface clint_timer_if;
  logic        req_valid_in;
  logic        req_ready_out;
  logic        req_we_in;
  logic [15:0] req_addr_in;
  logic [31:0] req_wdata_in;
  logic [3:0]  req_wstrb_in;
  logic        rsp_valid_out;
  logic [31:0] rsp_rdata_out;
  logic        rsp_error_out;

  modport master (
    output req_valid_in, req_we_in, req_addr_in, req_wdata_in, req_wstrb_in,
    input  req_ready_out, rsp_valid_out, rsp_rdata_out, rsp_error_out
  );

  modport slave (
    input  req_valid_in, req_we_in, req_addr_in, req_wdata_in, req_wstrb_in,
    output req_ready_out, rsp_valid_out, rsp_rdata_out, rsp_error_out
  );
endinterface

// File: rtl/clint_timer.sv
// Core-local interruptor for a single hart: 64-bit mtime / mtimecmp and the
// msip software-interrupt bit, memory-mapped on the data bus.
//   clk              : core clock
//   reset            : synchronous, active-high reset
//   bus              : clint_timer_if slave (request/response channels)
//   timer_int_out    : registered (mtime >= mtimecmp), to CSR timer_int_in
//   software_int_out : msip[0], to CSR software_int_in
//   mtime_out        : current mtime register
// Register map: 0x0000 msip, 0x4000/0x4004 mtimecmp lo/hi,
//               0xBFF8/0xBFFC mtime lo/hi. Anything else, or a
//               non-word-aligned offset, responds with an error.
// TICK_DIV sets core clocks per mtime increment (1..65535); XLEN must be 32.
module clint_timer #(
  parameter int TICK_DIV = 1,
  parameter int XLEN     = 32
) (
  input  logic         clk,
  input  logic         reset,
  clint_timer_if.slave bus,
  output logic         timer_int_out,
  output logic         software_int_out,
  output logic [63:0]  mtime_out
);

  localparam logic [15:0] ADDR_MSIP    = 16'h0000;
  localparam logic [15:0] ADDR_CMP_LO  = 16'h4000;
  localparam logic [15:0] ADDR_CMP_HI  = 16'h4004;
  localparam logic [15:0] ADDR_TIME_LO = 16'hBFF8;
  localparam logic [15:0] ADDR_TIME_HI = 16'hBFFC;
  localparam logic [15:0] TICK_LAST    = 16'(TICK_DIV - 1);

  logic [63:0]     mtime;
  logic [63:0]     mtimecmp;
  logic            msip;
  logic [15:0]     presc;

  logic            accept;
  logic            tick;
  logic            aligned;
  logic            sel_msip;
  logic            sel_cmp_lo;
  logic            sel_cmp_hi;
  logic            sel_time_lo;
  logic            sel_time_hi;
  logic            hit;
  logic            wr;
  logic [XLEN-1:0] rd_val;
  logic [XLEN-1:0] msip_new;

  // Byte-lane merge of write data into an existing 32-bit word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (wstrb[i]) res[i*8 +: 8] = wdata[i*8 +: 8];
    end
    return res;
  endfunction

  // Ready is simply "not in reset"; there is never any other stall source.
  assign bus.req_ready_out = ~reset;

  always_comb begin
    accept      = bus.req_valid_in & bus.req_ready_out;
    aligned     = (bus.req_addr_in[1:0] == 2'b00);
    sel_msip    = aligned && (bus.req_addr_in == ADDR_MSIP);
    sel_cmp_lo  = aligned && (bus.req_addr_in == ADDR_CMP_LO);
    sel_cmp_hi  = aligned && (bus.req_addr_in == ADDR_CMP_HI);
    sel_time_lo = aligned && (bus.req_addr_in == ADDR_TIME_LO);
    sel_time_hi = aligned && (bus.req_addr_in == ADDR_TIME_HI);
    hit         = sel_msip | sel_cmp_lo | sel_cmp_hi | sel_time_lo | sel_time_hi;
    // Errored accesses never write anything.
    wr          = accept & bus.req_we_in & hit;
    tick        = (presc == TICK_LAST);

    rd_val = '0;
    if (sel_msip)    rd_val = {{(XLEN-1){1'b0}}, msip};
    if (sel_cmp_lo)  rd_val = mtimecmp[31:0];
    if (sel_cmp_hi)  rd_val = mtimecmp[63:32];
    if (sel_time_lo) rd_val = mtime[31:0];
    if (sel_time_hi) rd_val = mtime[63:32];

    msip_new = merge_bytes({{(XLEN-1){1'b0}}, msip}, bus.req_wdata_in, bus.req_wstrb_in);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mtime             <= '0;
      mtimecmp          <= '1;
      msip              <= 1'b0;
      presc             <= '0;
      timer_int_out     <= 1'b0;
      bus.rsp_valid_out <= 1'b0;
      bus.rsp_rdata_out <= '0;
      bus.rsp_error_out <= 1'b0;
    end else begin
      // Prescaler runs freely; mtime writes do not restart it.
      presc <= tick ? '0 : presc + 16'd1;

      // Compare uses the pre-edge register values, so the interrupt lags
      // any mtime/mtimecmp change by one cycle.
      timer_int_out <= (mtime >= mtimecmp);

      if (wr && sel_msip)   msip            <= msip_new[0];
      if (wr && sel_cmp_lo) mtimecmp[31:0]  <= merge_bytes(mtimecmp[31:0],  bus.req_wdata_in, bus.req_wstrb_in);
      if (wr && sel_cmp_hi) mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], bus.req_wdata_in, bus.req_wstrb_in);

      // A bus write to either mtime half suppresses that cycle's increment
      // entirely, carry included; the other half holds.
      if (wr && sel_time_lo) begin
        mtime[31:0]  <= merge_bytes(mtime[31:0],  bus.req_wdata_in, bus.req_wstrb_in);
      end else if (wr && sel_time_hi) begin
        mtime[63:32] <= merge_bytes(mtime[63:32], bus.req_wdata_in, bus.req_wstrb_in);
      end else if (tick) begin
        mtime <= mtime + 64'd1;
      end

      // Response one cycle after acceptance; read data is the pre-edge value.
      bus.rsp_valid_out <= accept;
      bus.rsp_error_out <= accept & ~hit;
      bus.rsp_rdata_out <= (accept && !bus.req_we_in && hit) ? rd_val : '0;
    end
  end

  assign software_int_out = msip;
  assign mtime_out        = mtime;

endmodule

// File: tb/tb_clint_timer.sv
// Testbench for clint_timer: two instances (TICK_DIV = 1 and 4) share one
// randomized/directed request stream and are compared every cycle against a
// behavioural register-map model, plus literal checks from the test plan.
module tb_clint_timer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        v;
  logic        we;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;

  clint_timer_if b1();
  clint_timer_if b4();

  assign b1.req_valid_in = v;
  assign b1.req_we_in    = we;
  assign b1.req_addr_in  = addr;
  assign b1.req_wdata_in = wdata;
  assign b1.req_wstrb_in = wstrb;
  assign b4.req_valid_in = v;
  assign b4.req_we_in    = we;
  assign b4.req_addr_in  = addr;
  assign b4.req_wdata_in = wdata;
  assign b4.req_wstrb_in = wstrb;

  logic        tint1, sw1, tint4, sw4;
  logic [63:0] mt1, mt4;

  clint_timer #(.TICK_DIV(1), .XLEN(32)) dut1 (
    .clk(clk), .reset(reset), .bus(b1),
    .timer_int_out(tint1), .software_int_out(sw1), .mtime_out(mt1)
  );

  clint_timer #(.TICK_DIV(4), .XLEN(32)) dut4 (
    .clk(clk), .reset(reset), .bus(b4),
    .timer_int_out(tint4), .software_int_out(sw4), .mtime_out(mt4)
  );

  int total;
  int bad;
  logic chk_en;

  // Model state, index 0 = TICK_DIV 1, index 1 = TICK_DIV 4.
  longint unsigned m_cnt [2];
  logic [63:0]     m_time[2];
  logic [63:0]     m_cmp [2];
  logic            m_msip[2];
  logic            m_tint[2];
  logic            m_rv  [2];
  logic            m_re  [2];
  logic [31:0]     m_rd  [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = s[i] ? d[i*8 +: 8] : o[i*8 +: 8];
    return r;
  endfunction

  // One clock edge of the register map as the specification describes it.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      longint unsigned d;
      logic            tick;
      logic            err;
      logic            time_wr;
      int              rid;
      logic [31:0]     cur;
      logic [31:0]     nw;
      d = (k == 0) ? 64'd1 : 64'd4;
      if (reset) begin
        m_cnt[k] = 0; m_time[k] = '0; m_cmp[k] = '1; m_msip[k] = 1'b0;
        m_tint[k] = 1'b0; m_rv[k] = 1'b0; m_re[k] = 1'b0; m_rd[k] = '0;
      end else begin
        tick = ((m_cnt[k] % d) == d - 1);
        m_cnt[k]++;
        m_tint[k] = (m_time[k] >= m_cmp[k]);
        case (addr)
          16'h0000: rid = 0;
          16'h4000: rid = 1;
          16'h4004: rid = 2;
          16'hBFF8: rid = 3;
          16'hBFFC: rid = 4;
          default:  rid = -1;
        endcase
        err = (rid < 0);
        case (rid)
          0:       cur = {31'b0, m_msip[k]};
          1:       cur = m_cmp[k][31:0];
          2:       cur = m_cmp[k][63:32];
          3:       cur = m_time[k][31:0];
          4:       cur = m_time[k][63:32];
          default: cur = '0;
        endcase
        m_rv[k] = v;
        m_re[k] = v && err;
        m_rd[k] = (v && !we && !err) ? cur : 32'h0;
        time_wr = 1'b0;
        if (v && we && !err) begin
          nw = lanes(cur, wdata, wstrb);
          case (rid)
            0: m_msip[k] = nw[0];
            1: m_cmp[k][31:0] = nw;
            2: m_cmp[k][63:32] = nw;
            3: begin m_time[k][31:0] = nw; time_wr = 1'b1; end
            4: begin m_time[k][63:32] = nw; time_wr = 1'b1; end
            default: ;
          endcase
        end
        if (!time_wr && tick) m_time[k] = m_time[k] + 64'd1;
      end
    end
  endtask

  // Per-cycle compare of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready_d1", {63'b0, b1.req_ready_out}, {63'b0, !reset});
      chk("rvalid_d1", {63'b0, b1.rsp_valid_out}, {63'b0, m_rv[0]});
      chk("rerror_d1", {63'b0, b1.rsp_error_out}, {63'b0, m_re[0]});
      chk("rdata_d1", {32'b0, b1.rsp_rdata_out}, {32'b0, m_rd[0]});
      chk("tint_d1", {63'b0, tint1}, {63'b0, m_tint[0]});
      chk("swint_d1", {63'b0, sw1}, {63'b0, m_msip[0]});
      chk("mtime_d1", mt1, m_time[0]);
      chk("ready_d4", {63'b0, b4.req_ready_out}, {63'b0, !reset});
      chk("rvalid_d4", {63'b0, b4.rsp_valid_out}, {63'b0, m_rv[1]});
      chk("rerror_d4", {63'b0, b4.rsp_error_out}, {63'b0, m_re[1]});
      chk("rdata_d4", {32'b0, b4.rsp_rdata_out}, {32'b0, m_rd[1]});
      chk("tint_d4", {63'b0, tint4}, {63'b0, m_tint[1]});
      chk("swint_d4", {63'b0, sw4}, {63'b0, m_msip[1]});
      chk("mtime_d4", mt4, m_time[1]);
    end
  end

  // Advance one clock; returns just after the following falling edge.
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic req(input logic w, input logic [15:0] a, input logic [31:0] d,
                     input logic [3:0] s);
    v = 1'b1; we = w; addr = a; wdata = d; wstrb = s;
    step();
    v = 1'b0; we = 1'b0; addr = '0; wdata = '0; wstrb = '0;
  endtask

  logic [15:0] addr_tab [8];
  bit found;

  initial begin
    total = 0; bad = 0; chk_en = 1'b0;
    reset = 1'b1; v = 1'b0; we = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    addr_tab[0] = 16'h0000; addr_tab[1] = 16'h4000; addr_tab[2] = 16'h4004;
    addr_tab[3] = 16'hBFF8; addr_tab[4] = 16'hBFFC; addr_tab[5] = 16'h1234;
    addr_tab[6] = 16'h4002; addr_tab[7] = 16'hBFFA;

    step();
    chk_en = 1'b1;
    step();
    chk("reset_mtime", mt1, 64'd0);
    chk("reset_ready", {63'b0, b1.req_ready_out}, 64'd0);
    chk("reset_rvalid", {63'b0, b1.rsp_valid_out}, 64'd0);

    // Idle counting with both prescaler settings.
    reset = 1'b0;
    repeat (5) step();
    chk("idle5_mtime", mt1, 64'd5);
    chk("idle5_tint", {63'b0, tint1}, 64'd0);
    chk("idle5_sw", {63'b0, sw1}, 64'd0);
    repeat (11) step();
    chk("div4_16cyc", mt4, 64'd4);
    chk("div1_16cyc", mt1, 64'd16);
    repeat (3) step();
    chk("div4_19cyc", mt4, 64'd4);
    step();
    chk("div4_20cyc", mt4, 64'd5);

    // Carry from low into high word.
    req(1'b1, 16'hBFF8, 32'hFFFF_FFFF, 4'hF);
    req(1'b1, 16'hBFFC, 32'h0, 4'hF);
    chk("carry_pre", mt1, 64'h0000_0000_FFFF_FFFF);
    step();
    chk("carry_post", mt1, 64'h0000_0001_0000_0000);
    req(1'b0, 16'hBFFC, 32'h0, 4'h0);
    chk("read_hi_valid", {63'b0, b1.rsp_valid_out}, 64'd1);
    chk("read_hi_data", {32'b0, b1.rsp_rdata_out}, 64'd1);

    // Software interrupt.
    req(1'b1, 16'h0000, 32'h1, 4'hF);
    chk("msip_set", {63'b0, sw1}, 64'd1);
    req(1'b0, 16'h0000, 32'h0, 4'h0);
    chk("msip_read", {32'b0, b1.rsp_rdata_out}, 64'd1);
    req(1'b1, 16'h0000, 32'h0, 4'hF);
    chk("msip_clr", {63'b0, sw1}, 64'd0);

    // Timer interrupt at mtimecmp = 10.
    req(1'b1, 16'h4004, 32'h0, 4'hF);
    req(1'b1, 16'h4000, 32'd10, 4'hF);
    req(1'b1, 16'hBFFC, 32'h0, 4'hF);
    req(1'b1, 16'hBFF8, 32'h0, 4'hF);
    chk("cmp_mtime0", mt1, 64'd0);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mt1 == 64'd10) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("reach10", {63'b0, found}, 64'd1);
    chk("tint_lag", {63'b0, tint1}, 64'd0);
    step();
    chk("tint_rise", {63'b0, tint1}, 64'd1);
    req(1'b1, 16'h4004, 32'h1, 4'hF);
    chk("tint_hold", {63'b0, tint1}, 64'd1);
    step();
    chk("tint_clear", {63'b0, tint1}, 64'd0);

    // Error accesses.
    req(1'b0, 16'h1234, 32'h0, 4'h0);
    chk("err1_valid", {63'b0, b1.rsp_valid_out}, 64'd1);
    chk("err1_error", {63'b0, b1.rsp_error_out}, 64'd1);
    chk("err1_data", {32'b0, b1.rsp_rdata_out}, 64'd0);
    req(1'b1, 16'h4002, 32'hFFFF_FFFF, 4'hF);
    chk("err2_error", {63'b0, b1.rsp_error_out}, 64'd1);
    req(1'b0, 16'h4000, 32'h0, 4'h0);
    chk("err2_nochg", {32'b0, b1.rsp_rdata_out}, 64'd10);
    chk("err2_noerr", {63'b0, b1.rsp_error_out}, 64'd0);

    // Reset while a read is presented.
    req(1'b1, 16'h0000, 32'h1, 4'h1);
    v = 1'b1; we = 1'b0; addr = 16'hBFF8; reset = 1'b1;
    step();
    v = 1'b0; addr = '0;
    chk("rstrd_valid", {63'b0, b1.rsp_valid_out}, 64'd0);
    chk("rstrd_mtime", mt1, 64'd0);
    chk("rstrd_sw", {63'b0, sw1}, 64'd0);
    chk("rstrd_tint", {63'b0, tint1}, 64'd0);
    reset = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      v     = ($urandom_range(0, 3) != 0);
      we    = $urandom_range(0, 1);
      addr  = ($urandom_range(0, 9) == 0) ? 16'($urandom) : addr_tab[$urandom_range(0, 7)];
      wdata = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 60)) : $urandom;
      wstrb = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
      step();
    end
    reset = 1'b0; v = 1'b0;
    step();
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
